call_stack_ctrl: RTL and testbench
==================================

# call_stack_ctrl

Hardware return-address stack controller for the multicycle core. On CALL it saves the return PC, and on RET it supplies the saved PC to the PC-source mux. Pushes and pops are committed only on the stage sequencer's push/pop strobe. The block detects overflow and underflow, latches an error and requests a halt so the control unit can force the HALT PC source.

## Interface
Parameters:
- ADDR_W, 32, width of a stored PC.
- DEPTH, 16, number of entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- push  in  1  push request from control (CALL).
- pop  in  1  pop request from control (RET).
- commit  in  1  one-cycle strobe from the stage sequencer; push/pop act only when high.
- push_addr  in  ADDR_W  return PC to save.
- err_clr  in  1  clears a latched error.
- top_addr  out  ADDR_W  registered copy of the current top entry; 0 when empty.
- count  out  $clog2(DEPTH)+1  number of valid entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- err  out  1  sticky error flag.
- err_code  out  2  00 none, 01 overflow, 10 underflow.
- halt  out  1  high while in ERROR.

## Operation
- Reset (reset low at a clock edge) takes priority over everything else:
  - top_addr=0, count=0, empty=1, full=0, err=0, err_code=00, halt=0, state RUN.
  - Storage contents are don't-care.
- State RUN, with commit high:
  - Push only: write push_addr at index sp, sp←sp+1, count+1, top_addr←push_addr.
  - Pop only: sp←sp−1, count−1, top_addr←entry at the new top (0 if the stack becomes empty).
  - Push and pop together (replace top), non-empty stack: overwrite the top entry with push_addr; count unchanged; top_addr←push_addr.
  - Push and pop together, empty stack: treated as a plain push.
  - Pop while empty: no state change; err=1, err_code=10, go to ERROR.
  - Push while full: see Configuration.
- Any request with commit low is ignored.
- State ERROR:
  - All push/pop requests are ignored; halt=1.
  - err_clr high → next state RUN, err=0, err_code=00.
  - Stack contents and count remain exactly as they were before the failing operation.
  - A commit in the same cycle as err_clr is ignored.
- err_clr in RUN has no effect.
- sp wraps modulo DEPTH. count is kept separately and never wraps.

## Timing
- All outputs are registered.
- Effect of a committed operation is visible on top_addr/count/empty/full/err the cycle after the commit edge. Latency is 1 cycle.
- halt rises the cycle after the faulting commit and falls the cycle after err_clr.
- One operation per commit. Back-to-back commits on consecutive cycles are legal and each takes effect.
- Reset mid-sequence discards any pending operation; the first edge after reset rises is state RUN, empty.

## Configuration
- CALL_STACK_WRAP_EN defined:
  - Push while full overwrites the oldest entry, with sp wrapping.
  - count stays DEPTH, full stays 1, and no error is raised.
  - Subsequent pops return the most recent DEPTH entries and then reach empty.
- CALL_STACK_WRAP_EN undefined:
  - Push while full makes no change; err=1, err_code=01, state ERROR.
- Underflow behaviour is identical in both builds.

## Structure
- The shared core package holds:
  - Error code constants: ERR_NONE, ERR_OVF, ERR_UNF.
  - FSM state encoding: ST_RUN, ST_ERROR.
  - The default stack depth constant.
- One sub-module, stack_ram: DEPTH×ADDR_W storage with one synchronous write port and one asynchronous read port.
- Pointer, count and FSM logic live in call_stack_ctrl.

## Test plan
- After reset, push 0x0000_0040 then 0x0000_0080, each with commit → count=2, top_addr=0x80. Pop → top_addr=0x40, count=1. Pop → empty=1, top_addr=0.
- Push with commit low for 3 cycles → count stays 0, top_addr stays 0.
- Pop while empty → next cycle err=1, err_code=10, halt=1. A push of 0x100 while halted is ignored. err_clr → halt=0, count=0.
- DEPTH=4: push 0x10,0x20,0x30,0x40, then push 0x50.
  - Without the macro: err_code=01, top_addr=0x40, count=4.
  - With CALL_STACK_WRAP_EN: top_addr=0x50, count=4, and four pops return 0x50,0x40,0x30,0x20.
- Stack holding 0x10,0x20: push 0x99 and pop together with commit → count=2, top_addr=0x99. Pop → top_addr=0x10.
- Reset low in the same cycle as a committed push of 0x44 → empty=1, count=0, top_addr=0.

Source files
------------

// File: rtl/call_stack_ctrl_pkg.sv
// call_stack_ctrl_pkg: shared error codes, FSM states and default depth for the return-address stack
package call_stack_ctrl_pkg;
  localparam int DEFAULT_DEPTH = 16;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;
  typedef enum logic {ST_RUN, ST_ERROR} state_t;
endpackage

// File: rtl/call_stack_ctrl_if.sv
// call_stack_ctrl_if: stack bus; master drives push/pop/commit/push_addr/err_clr, slave returns top_addr/count/empty/full/err/err_code/halt
interface call_stack_ctrl_if import call_stack_ctrl_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = DEFAULT_DEPTH
);
  logic push, pop, commit, err_clr;
  logic [ADDR_W-1:0] push_addr, top_addr;
  logic [$clog2(DEPTH):0] count;
  logic empty, full, err, halt;
  logic [1:0] err_code;
  modport master(output push, pop, commit, push_addr, err_clr,
                 input top_addr, count, empty, full, err, err_code, halt);
  modport slave(input push, pop, commit, push_addr, err_clr,
                output top_addr, count, empty, full, err, err_code, halt);
endinterface

// File: rtl/call_stack_ctrl_stack_ram.sv
// stack_ram: DEPTH x ADDR_W storage (clk; we/waddr/wdata sync write; raddr/rdata async read)
module stack_ram #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [ADDR_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [ADDR_W-1:0]        rdata
);
  logic [ADDR_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/call_stack_ctrl.sv
// call_stack_ctrl: return-address stack (clk, reset sync active-low, bus slave: push/pop/commit/push_addr/err_clr in, top_addr/count/empty/full/err/err_code/halt out); CALL_STACK_WRAP_EN makes push-on-full overwrite the oldest entry
module call_stack_ctrl import call_stack_ctrl_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input logic          clk,
  input logic          reset,
  call_stack_ctrl_if.slave bus
);
  localparam int SP_W  = $clog2(DEPTH);
  localparam int CNT_W = SP_W + 1;
  state_t state, state_n;
  logic [SP_W-1:0] sp, sp_n, waddr, raddr;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ADDR_W-1:0] top_q, top_n, rdata;
  logic [1:0] code_q, code_n;
  logic empty_q, full_q, we;
  stack_ram #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .we(we && reset), .waddr(waddr), .wdata(bus.push_addr),
    .raddr(raddr), .rdata(rdata)
  );
  // sp points at the next free slot, so after a pop the new top lives at sp-2
  always_comb begin
    state_n = state;
    sp_n    = sp;
    cnt_n   = cnt;
    top_n   = top_q;
    code_n  = code_q;
    we      = 1'b0;
    waddr   = sp;
    raddr   = sp - SP_W'(2);
    if (state == ST_ERROR) begin
      state_n = bus.err_clr ? ST_RUN : ST_ERROR;
      code_n  = bus.err_clr ? ERR_NONE : code_q;
    end else if (bus.commit) begin
      if (bus.push && bus.pop && !empty_q) begin
        we    = 1'b1;
        waddr = sp - SP_W'(1);
        top_n = bus.push_addr;
      end else if (bus.push && full_q) begin
`ifdef CALL_STACK_WRAP_EN
        we    = 1'b1;
        sp_n  = sp + SP_W'(1);
        top_n = bus.push_addr;
`else
        state_n = ST_ERROR;
        code_n  = ERR_OVF;
`endif
      end else if (bus.push) begin
        we    = 1'b1;
        sp_n  = sp + SP_W'(1);
        cnt_n = cnt + CNT_W'(1);
        top_n = bus.push_addr;
      end else if (bus.pop && empty_q) begin
        state_n = ST_ERROR;
        code_n  = ERR_UNF;
      end else if (bus.pop) begin
        sp_n  = sp - SP_W'(1);
        cnt_n = cnt - CNT_W'(1);
        top_n = (cnt == CNT_W'(1)) ? '0 : rdata;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_RUN;
      sp      <= '0;
      cnt     <= '0;
      top_q   <= '0;
      code_q  <= ERR_NONE;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      state   <= state_n;
      sp      <= sp_n;
      cnt     <= cnt_n;
      top_q   <= top_n;
      code_q  <= code_n;
      empty_q <= cnt_n == '0;
      full_q  <= cnt_n == CNT_W'(DEPTH);
    end
  end
  assign bus.top_addr = top_q;
  assign bus.count    = cnt;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.err      = state == ST_ERROR;
  assign bus.halt     = state == ST_ERROR;
  assign bus.err_code = code_q;
endmodule

// File: tb/tb_call_stack_ctrl.sv
// tb_call_stack_ctrl: directed self-checking bench for call_stack_ctrl at DEPTH=4 (both CALL_STACK_WRAP_EN builds)
module tb_call_stack_ctrl;
  localparam int AW = 32;
  localparam int D  = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  call_stack_ctrl_if #(.ADDR_W(AW), .DEPTH(D)) bus();
  call_stack_ctrl #(.ADDR_W(AW), .DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic expect_st(input string tag, input logic [31:0] top, input int cnt,
                           input logic e, input logic f, input logic er,
                           input logic [1:0] code, input logic h);
    chk({tag, ".top"}, bus.top_addr, top);
    chk({tag, ".count"}, 32'(bus.count), cnt);
    chk({tag, ".empty"}, 32'(bus.empty), 32'(e));
    chk({tag, ".full"}, 32'(bus.full), 32'(f));
    chk({tag, ".err"}, 32'(bus.err), 32'(er));
    chk({tag, ".code"}, 32'(bus.err_code), 32'(code));
    chk({tag, ".halt"}, 32'(bus.halt), 32'(h));
  endtask
  task automatic step(input logic p, input logic q, input logic c, input logic clr,
                      input logic [31:0] a);
    bus.push = p;
    bus.pop = q;
    bus.commit = c;
    bus.err_clr = clr;
    bus.push_addr = a;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.push = 0; bus.pop = 0; bus.commit = 0; bus.err_clr = 0; bus.push_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_st("rst", 0, 0, 1, 0, 0, 2'b00, 0);
    reset = 1'b1;
    step(1, 0, 1, 0, 32'h40); expect_st("p40", 32'h40, 1, 0, 0, 0, 2'b00, 0);
    step(1, 0, 1, 0, 32'h80); expect_st("p80", 32'h80, 2, 0, 0, 0, 2'b00, 0);
    step(0, 1, 1, 0, 0);      expect_st("pop1", 32'h40, 1, 0, 0, 0, 2'b00, 0);
    step(0, 1, 1, 0, 0);      expect_st("pop2", 0, 0, 1, 0, 0, 2'b00, 0);
    repeat (3) step(1, 0, 0, 0, 32'h55);
    expect_st("nocommit", 0, 0, 1, 0, 0, 2'b00, 0);
    step(0, 1, 1, 0, 0);      expect_st("unf", 0, 0, 1, 0, 1, 2'b10, 1);
    step(1, 0, 1, 0, 32'h100); expect_st("halted", 0, 0, 1, 0, 1, 2'b10, 1);
    step(0, 0, 0, 1, 0);      expect_st("clr", 0, 0, 1, 0, 0, 2'b00, 0);
    step(0, 1, 1, 0, 0);      expect_st("unf2", 0, 0, 1, 0, 1, 2'b10, 1);
    step(1, 0, 1, 1, 32'h33); expect_st("clrcommit", 0, 0, 1, 0, 0, 2'b00, 0);
    step(1, 0, 1, 0, 32'h10);
    step(1, 0, 1, 0, 32'h20);
    step(1, 0, 1, 0, 32'h30);
    step(1, 0, 1, 0, 32'h40); expect_st("full", 32'h40, 4, 0, 1, 0, 2'b00, 0);
    step(1, 0, 1, 0, 32'h50);
`ifdef CALL_STACK_WRAP_EN
    expect_st("wrap", 32'h50, 4, 0, 1, 0, 2'b00, 0);
    step(0, 1, 1, 0, 0); expect_st("wpop1", 32'h40, 3, 0, 0, 0, 2'b00, 0);
    step(0, 1, 1, 0, 0); expect_st("wpop2", 32'h30, 2, 0, 0, 0, 2'b00, 0);
    step(0, 1, 1, 0, 0); expect_st("wpop3", 32'h20, 1, 0, 0, 0, 2'b00, 0);
    step(0, 1, 1, 0, 0); expect_st("wpop4", 0, 0, 1, 0, 0, 2'b00, 0);
`else
    expect_st("ovf", 32'h40, 4, 0, 1, 1, 2'b01, 1);
    step(0, 0, 0, 1, 0); expect_st("ovfclr", 32'h40, 4, 0, 1, 0, 2'b00, 0);
    step(0, 1, 1, 0, 0); expect_st("opop1", 32'h30, 3, 0, 0, 0, 2'b00, 0);
    step(0, 1, 1, 0, 0); expect_st("opop2", 32'h20, 2, 0, 0, 0, 2'b00, 0);
    step(0, 1, 1, 0, 0); expect_st("opop3", 32'h10, 1, 0, 0, 0, 2'b00, 0);
    step(0, 1, 1, 0, 0); expect_st("opop4", 0, 0, 1, 0, 0, 2'b00, 0);
`endif
    step(1, 0, 1, 0, 32'h10);
    step(1, 0, 1, 0, 32'h20);
    step(1, 1, 1, 0, 32'h99); expect_st("repl", 32'h99, 2, 0, 0, 0, 2'b00, 0);
    step(0, 1, 1, 0, 0);      expect_st("rpop", 32'h10, 1, 0, 0, 0, 2'b00, 0);
    step(0, 1, 1, 0, 0);      expect_st("rpop2", 0, 0, 1, 0, 0, 2'b00, 0);
    step(1, 0, 1, 0, 32'h77); expect_st("p77", 32'h77, 1, 0, 0, 0, 2'b00, 0);
    reset = 1'b0;
    step(1, 0, 1, 0, 32'h44); expect_st("rstmid", 0, 0, 1, 0, 0, 2'b00, 0);
    reset = 1'b1;
    step(1, 1, 1, 0, 32'h12); expect_st("pp_empty", 32'h12, 1, 0, 0, 0, 2'b00, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
